// File: rtl/top_pkg.sv
// Shared types and constants for the all-pairs min/max distance block.
// Defining PAIR_INDEX_EN adds the winning pair indices to the result bytes.
package top_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPARE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  typedef logic signed [15:0] operand_t;
  typedef logic        [15:0] dist_t;

  localparam logic [7:0] MIN_ADDR = 8'd66;
  localparam logic [7:0] MAX_ADDR = 8'd68;
  localparam logic [7:0] IDX_ADDR = 8'd70;
  localparam int         NUM_VALS = 32;

  // Address of the final result byte; reaching it ends the WRITE phase.
`ifdef PAIR_INDEX_EN
  localparam logic [7:0] LAST_ADDR = IDX_ADDR + 8'd3;
`else
  localparam logic [7:0] LAST_ADDR = IDX_ADDR - 8'd1;
`endif

  function automatic dist_t abs_diff(input operand_t a, input operand_t b);
    logic [16:0] d;
    logic [16:0] n;
    d = {a[15], a} - {b[15], b};
    n = 17'd0 - d;
    return d[16] ? 16'(n) : 16'(d);
  endfunction

endpackage

// File: rtl/data_mem.sv
// 256 x 8 data memory: asynchronous read, synchronous write, never reset.
module data_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] core [256];

  assign rdata = core[raddr];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) begin
      core[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/rf16x8.sv
// 16 x 8 register array; not reset, contents are not consumed by the datapath.
module rf16x8 (
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] Core [16];

  assign rdata = Core[addr];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) begin
      Core[addr] <= wdata;
    end
  end
endmodule

// File: rtl/top.sv
// All-pairs min/max absolute distance over 32 signed 16-bit values held in dm.core[0..63].
// Optional macro PAIR_INDEX_EN also records and writes the (j,k) indices of both winners.
module top
  import top_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic done
);
  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] j_q, j_d, k_q, k_d;
  dist_t      min_q, min_d, max_q, max_d;
  dist_t      dist_s;
  logic       done_q, done_d;
  operand_t   cache_q [NUM_VALS];
  logic [7:0] rdata_s, wdata_s, waddr_s;
  logic       we_s;
  logic [7:0] rf_rdata_s;
  logic       unused_rf_s;
`ifdef PAIR_INDEX_EN
  logic [4:0] min_j_q, min_j_d, min_k_q, min_k_d;
  logic [4:0] max_j_q, max_j_d, max_k_q, max_k_d;
`endif

  // Reset gates the write strobe so an abort during WRITE leaves memory untouched.
  assign waddr_s     = MIN_ADDR + {2'b00, cnt_q};
  assign we_s        = (state_q == S_WRITE) && !reset;
  assign dist_s      = abs_diff(cache_q[j_q], cache_q[k_q]);
  assign done        = done_q;
  assign unused_rf_s = ^rf_rdata_s;

  data_mem dm (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr ({2'b00, cnt_q}),
    .rdata (rdata_s)
  );

  rf16x8 RF1 (
    .clk   (clk),
    .we    (1'b0),
    .addr  (4'd0),
    .wdata (8'd0),
    .rdata (rf_rdata_s)
  );

  // Result byte selected by the current write address.
  always_comb begin
    wdata_s = 8'd0;
    case (waddr_s)
      MIN_ADDR:         wdata_s = min_q[15:8];
      MIN_ADDR + 8'd1:  wdata_s = min_q[7:0];
      MAX_ADDR:         wdata_s = max_q[15:8];
      MAX_ADDR + 8'd1:  wdata_s = max_q[7:0];
`ifdef PAIR_INDEX_EN
      IDX_ADDR:         wdata_s = {3'b000, min_j_q};
      IDX_ADDR + 8'd1:  wdata_s = {3'b000, min_k_q};
      IDX_ADDR + 8'd2:  wdata_s = {3'b000, max_j_q};
      IDX_ADDR + 8'd3:  wdata_s = {3'b000, max_k_q};
`endif
      default:          wdata_s = 8'd0;
    endcase
  end

  // Next-state logic for the sequencer, pair walker and accumulators.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    min_d   = min_q;
    max_d   = max_q;
    done_d  = done_q;
`ifdef PAIR_INDEX_EN
    min_j_d = min_j_q;
    min_k_d = min_k_q;
    max_j_d = max_j_q;
    max_k_d = max_k_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        cnt_d   = 6'd0;
        j_d     = 5'd0;
        k_d     = 5'd1;
        min_d   = 16'hFFFF;
        max_d   = 16'h0000;
        done_d  = 1'b0;
`ifdef PAIR_INDEX_EN
        min_j_d = 5'd0;
        min_k_d = 5'd1;
        max_j_d = 5'd0;
        max_k_d = 5'd1;
`endif
      end
      S_LOAD: begin
        if (cnt_q == 6'd63) begin
          state_d = S_COMPARE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_COMPARE: begin
        if (dist_s < min_q) begin
          min_d = dist_s;
`ifdef PAIR_INDEX_EN
          min_j_d = j_q;
          min_k_d = k_q;
`endif
        end else begin
          min_d = min_q;
        end
        if (dist_s > max_q) begin
          max_d = dist_s;
`ifdef PAIR_INDEX_EN
          max_j_d = j_q;
          max_k_d = k_q;
`endif
        end else begin
          max_d = max_q;
        end
        // Row j ends at k=31; the next row starts at k=j+1 of the new j.
        if (k_q == 5'd31) begin
          j_d = j_q + 5'd1;
          k_d = j_q + 5'd2;
          if (j_q == 5'd30) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_COMPARE;
          end
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      S_WRITE: begin
        if (waddr_s == LAST_ADDR) begin
          state_d = S_DONE;
          cnt_d   = 6'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; the operand cache is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      j_q     <= 5'd0;
      k_q     <= 5'd0;
      min_q   <= 16'hFFFF;
      max_q   <= 16'h0000;
      done_q  <= 1'b0;
`ifdef PAIR_INDEX_EN
      min_j_q <= 5'd0;
      min_k_q <= 5'd0;
      max_j_q <= 5'd0;
      max_k_q <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      min_q   <= min_d;
      max_q   <= max_d;
      done_q  <= done_d;
`ifdef PAIR_INDEX_EN
      min_j_q <= min_j_d;
      min_k_q <= min_k_d;
      max_j_q <= max_j_d;
      max_k_q <= max_k_d;
`endif
      if (state_q == S_LOAD) begin
        if (cnt_q[0]) begin
          cache_q[cnt_q[5:1]][7:0] <= rdata_s;
        end else begin
          cache_q[cnt_q[5:1]][15:8] <= rdata_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed and random operand sets against an all-pairs model.
module tb_top;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] img [256];

`ifdef PAIR_INDEX_EN
  localparam int DONE_EDGES = 569;
`else
  localparam int DONE_EDGES = 565;
`endif

  top dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_val(input int i, input logic [15:0] v);
    img[2*i]   = v[15:8];
    img[2*i+1] = v[7:0];
  endtask

  task automatic randomize_img();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
  endtask

  // Hold reset for one edge, load memory while it is high, release on a falling edge.
  task automatic start_run(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_rst_done"}, {31'd0, done}, 32'd0);
    for (int i = 0; i < 256; i++) dut.dm.core[i] = img[i];
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int edges;
    edges = 0;
    for (int e = 1; e <= DONE_EDGES + 50; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = e;
        break;
      end
    end
    check({tag, "_latency"}, edges, DONE_EDGES);
  endtask

  // Golden model: plain integer all-pairs scan with first-wins tie handling.
  task automatic check_results(input string tag, output int mn, output int mx);
    int vals [32];
    logic signed [15:0] sv;
    int d, mnj, mnk, mxj, mxk, bad;
    for (int i = 0; i < 32; i++) begin
      sv = {img[2*i], img[2*i+1]};
      vals[i] = sv;
    end
    mn = 65535; mx = 0;
    mnj = 0; mnk = 1; mxj = 0; mxk = 1;
    for (int j = 0; j < 32; j++) begin
      for (int k = j + 1; k < 32; k++) begin
        d = vals[j] - vals[k];
        if (d < 0) d = -d;
        if (d < mn) begin mn = d; mnj = j; mnk = k; end
        if (d > mx) begin mx = d; mxj = j; mxk = k; end
      end
    end
    check({tag, "_min"}, {16'd0, dut.dm.core[66], dut.dm.core[67]}, mn);
    check({tag, "_max"}, {16'd0, dut.dm.core[68], dut.dm.core[69]}, mx);
    bad = 0;
`ifdef PAIR_INDEX_EN
    check({tag, "_min_j"}, {24'd0, dut.dm.core[70]}, mnj);
    check({tag, "_min_k"}, {24'd0, dut.dm.core[71]}, mnk);
    check({tag, "_max_j"}, {24'd0, dut.dm.core[72]}, mxj);
    check({tag, "_max_k"}, {24'd0, dut.dm.core[73]}, mxk);
    for (int i = 0; i < 256; i++)
      if ((i < 64 || i > 73) && dut.dm.core[i] !== img[i]) bad++;
`else
    for (int i = 0; i < 256; i++)
      if ((i < 64 || i > 69) && dut.dm.core[i] !== img[i]) bad++;
`endif
    check({tag, "_untouched"}, bad, 0);
  endtask

  initial begin
    int mn, mx;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {31'd0, done}, 32'd0);

    // All values equal: every distance is zero.
    randomize_img();
    for (int i = 0; i < 32; i++) set_val(i, 16'h0005);
    start_run("equal");
    wait_done("equal");
    check_results("equal", mn, mx);
    check("equal_min_const", mn, 0);
    check("equal_max_const", mx, 0);

    // Arithmetic ramp 100*i.
    randomize_img();
    for (int i = 0; i < 32; i++) set_val(i, 16'(100 * i));
    start_run("ramp");
    wait_done("ramp");
    check_results("ramp", mn, mx);
    check("ramp_min_const", mn, 100);
    check("ramp_max_const", mx, 3100);
`ifdef PAIR_INDEX_EN
    check("ramp_max_k_const", {24'd0, dut.dm.core[73]}, 31);
`endif

    // Extreme span: most negative against most positive; back-to-back with the ramp run.
    randomize_img();
    for (int i = 0; i < 32; i++) set_val(i, 16'h0000);
    set_val(0, 16'h8000);
    set_val(31, 16'h7FFF);
    start_run("extreme");
    wait_done("extreme");
    check_results("extreme", mn, mx);
    check("extreme_max_const", mx, 65535);
    check("extreme_min_const", mn, 0);

    // Reset pulse mid-run aborts, then a fresh run completes normally.
    randomize_img();
    start_run("abort");
    repeat (200) @(posedge clk);
    #1;
    check("abort_pre_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_in_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_done("abort");
    check_results("abort", mn, mx);

    // Random signed data sets.
    for (int s = 0; s < 10; s++) begin
      randomize_img();
      start_run($sformatf("rand%0d", s));
      wait_done($sformatf("rand%0d", s));
      check_results($sformatf("rand%0d", s), mn, mx);
    end

    // Done is held while reset stays low.
    repeat (20) @(posedge clk);
    #1;
    check("done_held", {31'd0, done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
